hc_gather_n: RTL and testbench

// - Input side of the n-reduction: assembles a streamed hC vector (N_CHUNK n-values per beat, all h*p lanes)

---
 rtl/hc_gather_n_pkg.sv | 22 ++
 rtl/hc_gather_n.sv | 107 ++++++++++
 tb/tb_hc_gather_n.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/hc_gather_n_pkg.sv
// hc_gather_n_pkg
// Shared helpers for the n-reduction datapath (hc_gather_n and accum_n):
// beat-count derivation, counter width, and the flat (hp, n) element offset
// used to address the h*p*n buses. hp = h*P_TILE + p.
package hc_gather_n_pkg;

  // Number of input beats that make up one full vector.
  function automatic int calc_n_beats(input int n_total, input int n_chunk);
    return n_total / n_chunk;
  endfunction

  // Beat counter width; at least one bit even when a vector is a single beat.
  function automatic int calc_cnt_w(input int n_beats);
    return (n_beats <= 1) ? 1 : $clog2(n_beats);
  endfunction

  // LSB of element (hp, n) in a flat bus holding n_per_lane elements per lane.
  function automatic int elem_lsb(input int hp, input int n, input int n_per_lane, input int dw);
    return dw * (hp * n_per_lane + n);
  endfunction

endpackage

// File: rtl/hc_gather_n.sv
// hc_gather_n
// Assembles a streamed hC vector (N_CHUNK n-values per beat across all h*p
// lanes) into the flat h*p*n bus consumed by accum_n, then raises valid_o for
// one cycle. Downstream has no backpressure, so s_ready only drops in reset.
//
// Ports
//   clk      clock, rising edge
//   rst      asynchronous active-high reset
//   flush_i  discard the partially gathered vector (wins over a same-cycle beat)
//   s_valid  input beat valid
//   s_ready  input beat ready (1 whenever out of reset)
//   s_last   producer's end-of-vector marker (the beat counter is authoritative)
//   s_data   beat; element (hp,j) at DW*(hp*N_CHUNK+j)
//   hC_o     gathered vector; element (hp,n) at DW*(hp*N_TOTAL+n); held between pulses
//   valid_o  1-cycle pulse: hC_o holds a new complete vector
//   err_o    1-cycle pulse: framing error (early or missing s_last)
//   beat_o   current beat index (debug)
module hc_gather_n
  import hc_gather_n_pkg::*;
#(
  parameter int DW      = 16,
  parameter int H_TILE  = 1,
  parameter int P_TILE  = 1,
  parameter int N_TOTAL = 128,
  parameter int N_CHUNK = 16,
  localparam int N_BEATS = calc_n_beats(N_TOTAL, N_CHUNK),
  localparam int CNT_W   = calc_cnt_w(N_BEATS),
  localparam int HP      = H_TILE * P_TILE,
  localparam int BEAT_W  = HP * N_CHUNK * DW,
  localparam int VEC_W   = HP * N_TOTAL * DW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_last,
  input  logic [BEAT_W-1:0] s_data,
  output logic [VEC_W-1:0]  hC_o,
  output logic              valid_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  beat_o
);

  if (N_TOTAL % N_CHUNK != 0) begin : g_bad_chunk
    $error("hc_gather_n: N_TOTAL must be a multiple of N_CHUNK");
  end

  logic [CNT_W-1:0] beat_cnt;
  logic [VEC_W-1:0] gather_q;
  logic [VEC_W-1:0] gather_next;
  logic             accept;
  logic             final_beat;

  // No stall path: the output register is separate from the gather register.
  assign s_ready    = ~rst;
  assign accept     = s_valid & s_ready;
  assign final_beat = (beat_cnt == CNT_W'(N_BEATS - 1));
  assign beat_o     = beat_cnt;

  // Gather register with the current beat merged into its slot. Used both to
  // update the gather register and to load hC_o on the final beat, so the
  // emitted vector already includes the final beat's data.
  always_comb begin
    // NOTE: full default assignment first so no path through the loop can infer a latch.
    gather_next = gather_q;
    for (int hp = 0; hp < HP; hp++) begin
      for (int j = 0; j < N_CHUNK; j++) begin
        gather_next[elem_lsb(hp, int'(beat_cnt) * N_CHUNK + j, N_TOTAL, DW) +: DW] =
          s_data[elem_lsb(hp, j, N_CHUNK, DW) +: DW];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
      // NOTE: the gather register is wide but still reset, so a vector cut short by reset never leaks stale data.
      gather_q <= '0;
      hC_o     <= '0;
      valid_o  <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout so every flop samples pre-edge values regardless of statement order.
      valid_o <= 1'b0;
      err_o   <= 1'b0;
      if (flush_i) begin
        beat_cnt <= '0;
      end else if (accept) begin
        gather_q <= gather_next;
        if (final_beat) begin
          hC_o     <= gather_next;
          valid_o  <= 1'b1;
          err_o    <= ~s_last;
          beat_cnt <= '0;
        end else if (s_last) begin
          // Early s_last: drop the partial vector and resync to beat 0.
          err_o    <= 1'b1;
          beat_cnt <= '0;
        end else begin
          beat_cnt <= beat_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_hc_gather_n.sv
// tb_hc_gather_n
// Directed bench: default configuration (8 beats of 16 elements, one lane) and
// a single-beat configuration (H_TILE=2, P_TILE=2, N_CHUNK=N_TOTAL=128).
module tb_hc_gather_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance.
  logic          rst, flush, s_valid, s_last, s_ready, valid, err;
  logic [255:0]  s_data;
  logic [2047:0] hc;
  logic [2:0]    beat;

  // Single-beat instance.
  logic          rst1, flush1, s_valid1, s_last1, s_ready1, valid1, err1;
  logic [8191:0] s_data1;
  logic [8191:0] hc1;
  logic [0:0]    beat1;

  hc_gather_n dut (
    .clk(clk), .rst(rst), .flush_i(flush), .s_valid(s_valid), .s_ready(s_ready),
    .s_last(s_last), .s_data(s_data), .hC_o(hc), .valid_o(valid), .err_o(err), .beat_o(beat)
  );

  hc_gather_n #(.DW(16), .H_TILE(2), .P_TILE(2), .N_TOTAL(128), .N_CHUNK(128)) dut1 (
    .clk(clk), .rst(rst1), .flush_i(flush1), .s_valid(s_valid1), .s_ready(s_ready1),
    .s_last(s_last1), .s_data(s_data1), .hC_o(hc1), .valid_o(valid1), .err_o(err1), .beat_o(beat1)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Default beat k: element j = base + k*16 + j, so the full vector is base + n.
  function automatic logic [255:0] mk_beat(input logic [15:0] base, input int k);
    logic [255:0] b;
    for (int j = 0; j < 16; j++) b[16*j +: 16] = base + 16'(k * 16 + j);
    return b;
  endfunction

  // Number of elements of hc that differ from base + n.
  function automatic int vec_bad(input logic [2047:0] v, input logic [15:0] base);
    int bad = 0;
    for (int n = 0; n < 128; n++)
      if (v[16*n +: 16] !== base + 16'(n)) bad++;
    return bad;
  endfunction

  // Single-beat vector: element (hp,j) = salt + hp*0x100 + j.
  function automatic logic [8191:0] mk_beat1(input logic [15:0] salt);
    logic [8191:0] b;
    for (int hp = 0; hp < 4; hp++)
      for (int j = 0; j < 128; j++)
        b[16*(hp*128 + j) +: 16] = salt + 16'(hp * 256 + j);
    return b;
  endfunction

  // Drive one cycle on the default instance; returns 1 ns after the edge.
  task automatic step(input logic v, input logic l, input logic f, input logic [255:0] d);
    s_valid = v; s_last = l; flush = f; s_data = d;
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0; flush = 1'b0;
  endtask

  task automatic step1(input logic v, input logic l, input logic [8191:0] d);
    s_valid1 = v; s_last1 = l; s_data1 = d;
    @(posedge clk); #1;
    s_valid1 = 1'b0; s_last1 = 1'b0;
  endtask

  // Full 8-beat vector with s_last on the final beat.
  task automatic send_vec(input logic [15:0] base);
    for (int k = 0; k < 8; k++) step(1'b1, k == 7, 1'b0, mk_beat(base, k));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pulses;
    logic [8191:0] exp1;

    rst = 1'b1; rst1 = 1'b1;
    flush = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    flush1 = 1'b0; s_valid1 = 1'b0; s_last1 = 1'b0; s_data1 = '0;
    #12;
    check("rst_ready",  32'(s_ready), 32'd0);
    check("rst_valid",  32'(valid),   32'd0);
    check("rst_err",    32'(err),     32'd0);
    check("rst_beat",   32'(beat),    32'd0);
    check("rst_hc0",    32'(hc == '0), 32'd1);
    check("rst_ready1", 32'(s_ready1), 32'd0);
    rst = 1'b0; rst1 = 1'b0;
    #1;
    check("ready_out_of_rst", 32'(s_ready), 32'd1);
    @(posedge clk); #1;

    // Basic vector with an idle gap after beat 2.
    step(1'b1, 1'b0, 1'b0, mk_beat(16'h0000, 0));
    check("beat_after_1", 32'(beat), 32'd1);
    step(1'b1, 1'b0, 1'b0, mk_beat(16'h0000, 1));
    step(1'b1, 1'b0, 1'b0, mk_beat(16'h0000, 2));
    step(1'b0, 1'b0, 1'b0, '0);
    check("beat_idle_hold", 32'(beat), 32'd3);
    for (int k = 3; k < 7; k++) step(1'b1, 1'b0, 1'b0, mk_beat(16'h0000, k));
    check("no_valid_early", 32'(valid), 32'd0);
    step(1'b1, 1'b1, 1'b0, mk_beat(16'h0000, 7));
    check("v0_valid", 32'(valid), 32'd1);
    check("v0_err",   32'(err),   32'd0);
    check("v0_beat",  32'(beat),  32'd0);
    check("v0_data",  32'(vec_bad(hc, 16'h0000)), 32'd0);
    step(1'b0, 1'b0, 1'b0, '0);
    check("v0_pulse_1cyc", 32'(valid), 32'd0);

    // Back-to-back vectors, s_valid held high throughout.
    send_vec(16'h1000);
    check("b2b_a_valid", 32'(valid), 32'd1);
    check("b2b_a_data",  32'(vec_bad(hc, 16'h1000)), 32'd0);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      step(1'b1, k == 7, 1'b0, mk_beat(16'h2000, k));
      if (k == 0) check("b2b_hold", 32'(vec_bad(hc, 16'h1000)), 32'd0);
      if (k < 7) pulses += int'(valid);
    end
    check("b2b_gap_pulses", 32'(pulses), 32'd0);
    check("b2b_b_valid",    32'(valid), 32'd1);
    check("b2b_b_data",     32'(vec_bad(hc, 16'h2000)), 32'd0);

    // Early s_last on beat 3.
    for (int k = 0; k < 4; k++) step(1'b1, k == 3, 1'b0, mk_beat(16'h3000, k));
    check("early_err",   32'(err),   32'd1);
    check("early_valid", 32'(valid), 32'd0);
    check("early_beat",  32'(beat),  32'd0);
    check("early_hold",  32'(vec_bad(hc, 16'h2000)), 32'd0);
    step(1'b1, 1'b0, 1'b0, mk_beat(16'h4000, 0));
    check("early_err_1cyc", 32'(err), 32'd0);
    for (int k = 1; k < 8; k++) step(1'b1, k == 7, 1'b0, mk_beat(16'h4000, k));
    check("recov_valid", 32'(valid), 32'd1);
    check("recov_err",   32'(err),   32'd0);
    check("recov_data",  32'(vec_bad(hc, 16'h4000)), 32'd0);

    // Missing s_last on the final beat.
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 1'b0, mk_beat(16'h5000, k));
    check("nolast_valid", 32'(valid), 32'd1);
    check("nolast_err",   32'(err),   32'd1);
    check("nolast_data",  32'(vec_bad(hc, 16'h5000)), 32'd0);

    // Flush together with beat 5.
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0, mk_beat(16'h6000, k));
    check("pre_flush_beat", 32'(beat), 32'd5);
    step(1'b1, 1'b0, 1'b1, mk_beat(16'h6000, 5));
    check("flush_beat",  32'(beat),  32'd0);
    check("flush_err",   32'(err),   32'd0);
    check("flush_valid", 32'(valid), 32'd0);
    send_vec(16'h7000);
    check("post_flush_valid", 32'(valid), 32'd1);
    check("post_flush_data",  32'(vec_bad(hc, 16'h7000)), 32'd0);

    // Single-beat configuration: every beat emits.
    exp1 = mk_beat1(16'h1000);
    step1(1'b1, 1'b1, exp1);
    check("nb1_a_valid", 32'(valid1), 32'd1);
    check("nb1_a_data",  32'(hc1 === exp1), 32'd1);
    check("nb1_beat",    32'(beat1), 32'd0);
    exp1 = mk_beat1(16'h8000);
    step1(1'b1, 1'b1, exp1);
    check("nb1_b_valid", 32'(valid1), 32'd1);
    check("nb1_b_err",   32'(err1),   32'd0);
    check("nb1_b_data",  32'(hc1 === exp1), 32'd1);
    exp1 = mk_beat1(16'h4000);
    step1(1'b1, 1'b0, exp1);
    check("nb1_nolast_err", 32'(err1), 32'd1);
    check("nb1_nolast_data", 32'(hc1 === exp1), 32'd1);

    // Asynchronous reset between edges while valid1 is high.
    s_valid1 = 1'b1; s_last1 = 1'b1; s_data1 = mk_beat1(16'h2000);
    @(posedge clk); #1;
    check("nb1_pre_rst_valid", 32'(valid1), 32'd1);
    #1 rst1 = 1'b1;
    #1;
    check("async_rst_valid", 32'(valid1),   32'd0);
    check("async_rst_hc",    32'(hc1 == '0), 32'd1);
    check("async_rst_ready", 32'(s_ready1), 32'd0);
    check("async_rst_err",   32'(err1),     32'd0);
    @(posedge clk); #1;
    check("rst_held_valid", 32'(valid1), 32'd0);
    rst1 = 1'b0;
    s_valid1 = 1'b0; s_last1 = 1'b0;
    exp1 = mk_beat1(16'h3000);
    step1(1'b1, 1'b1, exp1);
    check("post_rst_valid", 32'(valid1), 32'd1);
    check("post_rst_data",  32'(hc1 === exp1), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
